ssp_bus_arbiter: RTL and testbench

- Shares the SSP's single WISHBONE register port between two requesters (0 = CPU, 1 = DMA) using round-robin arbitration.
- Sits between the requesters and the SSP slave port.
- Uses the SSP interrupt lines to hold back a TX write while the TX FIFO is full, and an RX read while the RX FIFO is empty.
- Runs one bus cycle at a time through a 3-state sequencer, with an optional watchdog.

---
 rtl/ssp_arb_pkg.sv | 23 ++
 rtl/ssp_rr_pick.sv | 15 +
 rtl/ssp_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_ssp_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_arb_pkg.sv
// Purpose : shared encodings for the SSP bus arbiter: sequencer states,
//           interrupt bit positions and the FIFO-blocking rule.
// Contents: ST_IDLE/ST_BUS/ST_DONE, TXF_BIT/RXNE_BIT, req_blocked().
package ssp_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TXF_BIT  = 1;    // ssp_intr_i: TX FIFO full
    localparam int RXNE_BIT = 0;    // ssp_intr_i: RX FIFO not empty

    // A data-register access is held back while its FIFO cannot take or
    // supply a byte; every other register is always accessible.
    function automatic logic req_blocked(input logic       we,
                                         input logic       at_tx,
                                         input logic [1:0] intr);
        if (!at_tx)
            return 1'b0;
        return we ? intr[TXF_BIT] : !intr[RXNE_BIT];
    endfunction

endpackage

// File: rtl/ssp_rr_pick.sv
// Purpose : combinational 2-way round-robin picker.
// Ports   : i_elig (eligibility mask), i_ptr (favoured requester when both
//           are eligible) -> o_win (one-hot winner), o_vld (any winner).
module ssp_rr_pick (
    input  logic [1:0] i_elig,
    input  logic       i_ptr,
    output logic [1:0] o_win,
    output logic       o_vld
);

    // A single eligible requester wins outright; the pointer only breaks ties.
    assign o_win = (&i_elig) ? (i_ptr ? 2'b10 : 2'b01) : i_elig;
    assign o_vld = |i_elig;

endmodule

// File: rtl/ssp_bus_arbiter.sv
// Purpose : shares the SSP WISHBONE register port between CPU (0) and DMA (1)
//           with round-robin arbitration and FIFO-aware request blocking.
// Ports   : clk_i/clear_n_i; req_i/we_i/adr*_i/dat*_i requester side with
//           gnt_o/ack_o/err_o/dat_o; wb_* master toward the SSP; ssp_intr_i.
// Config  : SSP_ARB_WATCHDOG_EN enables the BUS-state timeout (err_o).
module ssp_bus_arbiter
    import ssp_arb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 2,
    parameter int TX_ADR  = 0,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          clear_n_i,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] adr0_i,
    input  logic [AW-1:0] adr1_i,
    input  logic [DW-1:0] dat0_i,
    input  logic [DW-1:0] dat1_i,
    input  logic [1:0]    ssp_intr_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    ack_o,
    output logic [1:0]    err_o,
    output logic [DW-1:0] dat_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    logic [1:0]    r_state;
    logic          r_ptr;
    logic [1:0]    r_gnt;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_dat;
    logic          r_cyc;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdat;

    logic [1:0]    w_elig;
    logic [1:0]    w_win;
    logic          w_vld;

`ifdef SSP_ARB_WATCHDOG_EN
    logic [1:0]    r_err;
    logic [7:0]    r_wdog;
`else
    logic [7:0]    w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
`endif

    assign w_elig[0] = req_i[0] &&
                       !req_blocked(we_i[0], adr0_i == AW'(TX_ADR), ssp_intr_i);
    assign w_elig[1] = req_i[1] &&
                       !req_blocked(we_i[1], adr1_i == AW'(TX_ADR), ssp_intr_i);

    ssp_rr_pick u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_vld  (w_vld)
    );

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_dat   <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
`ifdef SSP_ARB_WATCHDOG_EN
            r_err   <= 2'b00;
            r_wdog  <= 8'd0;
`endif
        end else begin
            // Completion pulses last exactly the DONE cycle.
            r_ack <= 2'b00;
`ifdef SSP_ARB_WATCHDOG_EN
            r_err <= 2'b00;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_vld) begin
                        // Command is frozen here; later input changes are ignored.
                        r_gnt   <= w_win;
                        r_cyc   <= 1'b1;
                        r_we    <= w_win[1] ? we_i[1] : we_i[0];
                        r_adr   <= w_win[1] ? adr1_i  : adr0_i;
                        r_wdat  <= w_win[1] ? dat1_i  : dat0_i;
                        r_state <= ST_BUS;
`ifdef SSP_ARB_WATCHDOG_EN
                        r_wdog  <= 8'd0;
`endif
                    end
                end
                ST_BUS: begin
                    if (wb_ack_i) begin
                        if (!r_we)
                            r_dat <= wb_dat_i;
                        r_cyc   <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= ST_DONE;
`ifdef SSP_ARB_WATCHDOG_EN
                    end else if (r_wdog == 8'(TIMEOUT)) begin
                        // Ack in this same cycle takes the branch above instead.
                        r_cyc   <= 1'b0;
                        r_err   <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_wdog  <= r_wdog + 8'd1;
`endif
                    end
                end
                ST_DONE: begin
                    // Favour the requester that was not just served.
                    r_ptr   <= r_gnt[0];
                    r_gnt   <= 2'b00;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o    = r_gnt;
    assign ack_o    = r_ack;
    assign dat_o    = r_dat;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;
`ifdef SSP_ARB_WATCHDOG_EN
    assign err_o    = r_err;
`else
    assign err_o    = 2'b00;
`endif

endmodule

// File: tb/tb_ssp_bus_arbiter.sv
module tb_ssp_bus_arbiter;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [1:0] req, we, intr;
    logic [1:0] adr0, adr1;
    logic [7:0] dat0, dat1;
    logic [1:0] gnt_o, ack_o, err_o;
    logic [7:0] dat_o, wb_dat_o, wb_dat_i;
    logic       wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [1:0] wb_adr_o;

    logic       slv_en;
    logic [7:0] slv_dat;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ack;
        logic [1:0] err;
        logic       chk_dat;
        logic [7:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // Zero-wait slave when enabled: ack in the first strobe cycle.
    assign wb_ack_i = slv_en & wb_stb_o;
    assign wb_dat_i = slv_dat;

    ssp_bus_arbiter #(.DW(8), .AW(2), .TX_ADR(0), .TIMEOUT(4)) dut (
        .clk_i      (clk),
        .clear_n_i  (clear_n),
        .req_i      (req),
        .we_i       (we),
        .adr0_i     (adr0),
        .adr1_i     (adr1),
        .dat0_i     (dat0),
        .dat1_i     (dat1),
        .ssp_intr_i (intr),
        .gnt_o      (gnt_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .dat_o      (dat_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] e,
                        input logic c, input logic [7:0] d);
        exp_t x;
        x.ack = a; x.err = e; x.chk_dat = c; x.dat = d;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin tick(); n++; end while (gnt_o == 2'b00 && n < 30);
        chk(tag, gnt_o, exp);
    endtask

    // Wait for completion of requester k, then release its request.
    task automatic wait_ack(input int k);
        int n = 0;
        do begin tick(); n++; end while (!(ack_o[k] | err_o[k]) && n < 30);
        chk("wait_ack", ack_o[k] | err_o[k], 1);
        req[k] = 1'b0;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        tick();
    endtask

    // Scoreboard consumer: every completion pulse must match the queue head.
    always @(negedge clk) begin
        if (clear_n && (ack_o | err_o) != 2'b00) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", ack_o | err_o, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_ack", ack_o, mon_e.ack);
                chk("mon_err", err_o, mon_e.err);
                chk("mon_gnt", gnt_o, ack_o | err_o);
                if (mon_e.chk_dat)
                    chk("mon_dat", dat_o, mon_e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic any;
        int   n;
        req = 0; we = 0; intr = 2'b01; adr0 = 0; adr1 = 0; dat0 = 0; dat1 = 0;
        slv_en = 1'b1; slv_dat = 8'h00; clear_n = 1'b0;
        #12;
        chk("rst_outs", {gnt_o, ack_o, err_o, dat_o, wb_cyc_o, wb_stb_o,
                         wb_we_o, wb_adr_o, wb_dat_o}, 0);
        tick();
        clear_n = 1'b1;
        tick();

        // Single request, zero-wait slave.
        req[0] = 1; we[0] = 1; adr0 = 2'd1; dat0 = 8'hA5;
        push(2'b01, 2'b00, 1'b0, 8'h00);
        tick();
        chk("single_stb", wb_stb_o, 1);
        chk("single_cmd", {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 2'd1, 8'hA5});
        chk("single_gnt", gnt_o, 2'b01);
        tick();
        chk("single_ack", ack_o, 2'b01);
        chk("single_cyc_low", wb_cyc_o, 0);
        req[0] = 0;
        tick();
        chk("single_idle", {gnt_o, ack_o, wb_cyc_o}, 0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        we = 2'b00; adr0 = 2'd2; adr1 = 2'd3; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            slv_dat = 8'h10 + 8'(i);
            push((i % 2) ? 2'b10 : 2'b01, 2'b00, 1'b1, 8'h10 + 8'(i));
            wait_gnt("cont_gnt", (i % 2) ? 2'b10 : 2'b01);
            wait_ack(i % 2);
            tick();
            req[i % 2] = 1'b1;
        end
        req = 2'b00;
        tick(); tick(); tick();

        // TX full: requester 0 blocked, requester 1 served first.
        do_reset();
        intr = 2'b11;
        we = 2'b01; adr0 = 2'd0; dat0 = 8'h5A; adr1 = 2'd2; slv_dat = 8'h77;
        req = 2'b11;
        push(2'b10, 2'b00, 1'b1, 8'h77);
        push(2'b01, 2'b00, 1'b0, 8'h00);
        wait_gnt("txf_first", 2'b10);
        wait_ack(1);
        any = 0;
        for (int i = 0; i < 5; i++) begin tick(); any |= wb_cyc_o; end
        chk("txf_hold", any, 0);
        intr = 2'b01;
        wait_gnt("txf_second", 2'b01);
        chk("txf_cmd", {wb_we_o, wb_adr_o, wb_dat_o}, {1'b1, 2'd0, 8'h5A});
        wait_ack(0);
        tick();

        // RX empty: read of the data register held until bit [0] rises.
        intr = 2'b00;
        we = 2'b00; adr1 = 2'd0; req = 2'b10;
        any = 0;
        for (int i = 0; i < 20; i++) begin tick(); any |= wb_cyc_o; end
        chk("rxe_hold", any, 0);
        intr = 2'b01; slv_dat = 8'h3C;
        push(2'b10, 2'b00, 1'b1, 8'h3C);
        wait_gnt("rxe_gnt", 2'b10);
        wait_ack(1);
        chk("rxe_dat", dat_o, 8'h3C);
        tick();

`ifdef SSP_ARB_WATCHDOG_EN
        // Watchdog: silent slave, TIMEOUT=4.
        do_reset();
        slv_en = 1'b0;
        we = 2'b01; adr0 = 2'd1; dat0 = 8'h11; req = 2'b01;
        push(2'b00, 2'b01, 1'b0, 8'h00);
        n = 0;
        do begin tick(); n++; end while (!wb_stb_o && n < 30);
        n = 0;
        while (!err_o[0] && n < 20) begin tick(); n++; end
        chk("wd_latency", n, 5);
        chk("wd_cyc_low", wb_cyc_o, 0);
        req = 2'b00;
        tick();
        slv_en = 1'b1;
        we = 2'b00; adr0 = 2'd2; adr1 = 2'd3; req = 2'b11;
        push(2'b10, 2'b00, 1'b0, 8'h00);
        push(2'b01, 2'b00, 1'b0, 8'h00);
        wait_gnt("wd_next", 2'b10);
        wait_ack(1);
        wait_ack(0);
        tick();
`endif

        // Asynchronous reset while the bus cycle is open.
        slv_en = 1'b0;
        we = 2'b01; adr0 = 2'd1; dat0 = 8'h99; req = 2'b01;
        wait_gnt("rstmid_gnt", 2'b01);
        clear_n = 1'b0;
        #1;
        chk("rstmid_cyc", {wb_cyc_o, wb_stb_o}, 0);
        chk("rstmid_gnt0", gnt_o, 0);
        req = 2'b00;
        tick(); tick();
        clear_n = 1'b1;
        tick();
        chk("rstmid_outs", {gnt_o, ack_o, err_o, dat_o, wb_cyc_o, wb_stb_o,
                            wb_we_o, wb_adr_o, wb_dat_o}, 0);
        slv_en = 1'b1;
        we = 2'b00; adr0 = 2'd2; adr1 = 2'd3; req = 2'b11;
        push(2'b01, 2'b00, 1'b0, 8'h00);
        push(2'b10, 2'b00, 1'b0, 8'h00);
        wait_gnt("rstmid_ptr", 2'b01);
        wait_ack(0);
        wait_ack(1);
        tick(); tick();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
